risc_led_monitor: RTL and testbench
===================================

RISC_LED_MONITOR -- requirements
Module: risc_led_monitor

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the core result word being monitored.
REQ-002 Parameter LED_W, default 8, SHALL set the LED count; DATA_W SHALL be an integer multiple of LED_W.
REQ-003 Parameter DEPTH, default 8, power of 2, SHALL set the number of history entries.
REQ-004 Parameter DEB_CYCLES, default 1000000, SHALL set the number of stable cycles required to accept a button level.
REQ-005 Parameter HB_CYCLES, default 50000000, SHALL set the heartbeat half-period in cycles.
REQ-006 Port list (SEL_W = clog2(DATA_W/LED_W), min 1; CNT_W = clog2(DEPTH+1)):
 clk  in  1  system clock; one clock domain; all state on the rising edge.
 reset  in  1  asynchronous, active-high reset.
 data_in  in  DATA_W  core result word (ALU result).
 data_valid  in  1  data_in qualifier.
 btn_raw  in  1  raw, bouncing push-button (history step).
 freeze  in  1  1 = history browse mode, 0 = live mode.
 sw_sel  in  SEL_W  selects the LED_W-bit slice to display.
 led  out  LED_W  registered display output.
 hist_cnt  out  CNT_W  number of valid history entries.

Function
REQ-007 btn_raw SHALL pass through a 2-flop synchroniser before any other use.
REQ-008 Debounce: counter SHALL increment while the synced level differs from the debounced level, and SHALL clear whenever they match; the debounced level SHALL flip, and the counter SHALL clear, when the counter reaches DEB_CYCLES-1.
REQ-009 A debounced 0->1 transition SHALL produce a step pulse exactly one cycle wide.
REQ-010 Live register: on data_valid with freeze=0, live_reg SHALL load data_in.
REQ-011 History write: on data_valid with freeze=0, data_in SHALL be written at wr_ptr only if hist_cnt==0 or data_in differs from the newest entry; wr_ptr SHALL increment modulo DEPTH.
REQ-012 hist_cnt SHALL increment on each write and saturate at DEPTH; once the buffer is full, the oldest entry SHALL be overwritten.
REQ-013 Live mode: the display word SHALL be live_reg.
REQ-014 Browse mode: the display word SHALL be the entry rd_off places older than the newest; rd_off SHALL be 0 on entry to browse mode.
REQ-015 Each step pulse in browse mode SHALL increment rd_off, wrapping to 0 after hist_cnt-1; step pulses in live mode SHALL be ignored.
REQ-016 Browse mode with hist_cnt==0 SHALL display all zeros.
REQ-017 A freeze falling edge SHALL clear rd_off; writes SHALL resume on the next data_valid.
REQ-018 If data_valid coincides with a freeze rising edge, freeze SHALL win: no write, and live_reg is unchanged.
REQ-019 led SHALL register bits [sw_sel*LED_W +: LED_W] of the display word; an sw_sel value >= DATA_W/LED_W SHALL give zero.
REQ-020 Latency: data_valid at cycle N SHALL appear on led at cycle N+2; a sw_sel or rd_off change SHALL appear one cycle later.

Reset
REQ-021 Reset SHALL asynchronously clear led, hist_cnt, wr_ptr, rd_off, live_reg, the debounce counter, the debounced level, the synchroniser, the heartbeat counter and the heartbeat bit to 0.
REQ-022 Reset mid-operation SHALL discard history (hist_cnt=0); history RAM contents need not be cleared.

Configuration
REQ-023 With LED_HEARTBEAT_EN defined, led[LED_W-1] SHALL be replaced by a heartbeat bit that toggles every HB_CYCLES cycles, while led[LED_W-2:0] carries the slice.
REQ-024 Without LED_HEARTBEAT_EN, led SHALL carry the full LED_W-bit slice, and no heartbeat logic SHALL be synthesised.

Structure
REQ-025 Package risc_board_pkg SHALL hold the default constants (DATA_W, LED_W, DEPTH, DEB_CYCLES, HB_CYCLES) and a clog2-based width helper.
REQ-026 The debounce logic (REQ-007 to REQ-009) SHALL be a sub-module, btn_debounce, with output step_pulse.
REQ-027 History storage SHALL be an inferred register array; no vendor primitives.

Verification (DEB_CYCLES=4, DEPTH=4, DATA_W=32, LED_W=8)
REQ-028 Reset, then data_valid with data_in=0x12345678 and sw_sel=0 -> led=0x78 two cycles later; sw_sel=3 -> led=0x12 one cycle later.
REQ-029 btn_raw toggles every 2 cycles for 10 cycles, then is held high 6 cycles -> exactly one step pulse.
REQ-030 Write 0xA, 0xA, 0xB, 0xC, 0xD, 0xE -> hist_cnt=4; browse with three steps shows 0xE, 0xD, 0xC, 0xB; a fourth step shows 0xE.
REQ-031 freeze=1 with data_valid in the same cycle (data_in=0xFF) -> hist_cnt and led are unchanged.
REQ-032 Reset asserted mid-browse -> led=0 and hist_cnt=0 immediately (asynchronous); browse mode after release displays 0.
REQ-033 Build with LED_HEARTBEAT_EN and HB_CYCLES=3 -> led[7] toggles every 3 cycles and led[6:0] tracks the slice.

Source files
------------

// File: rtl/risc_board_pkg.sv
// Board-level default constants for the RISC LED monitor and a width helper
// used to size counters and selectors.
package risc_board_pkg;

    localparam int DATA_W     = 32;
    localparam int LED_W      = 8;
    localparam int DEPTH      = 8;
    localparam int DEB_CYCLES = 1000000;
    localparam int HB_CYCLES  = 50000000;

    // Bits needed to index `value` items, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces a raw push-button, emitting a one-cycle
// step_pulse for every accepted press (debounced 0->1 transition).
module btn_debounce
    import risc_board_pkg::clog2_min1;
#(
    parameter int DEB_CYCLES = risc_board_pkg::DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic step_pulse
);
    localparam int               CNT_W   = clog2_min1(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_step;
    logic             w_synced;
    logic             w_accept;

    assign w_synced = r_sync[1];
    assign w_accept = (w_synced != r_level) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

    // Any cycle where the synced level agrees with the accepted level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            r_step <= w_accept && w_synced;
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign step_pulse = r_step;

endmodule

// File: rtl/risc_led_monitor.sv
// Shows a core result word on LEDs, live or browsed from a deduplicated history ring.
// Define LED_HEARTBEAT_EN to replace the top LED with a heartbeat bit.
module risc_led_monitor
    import risc_board_pkg::clog2_min1;
#(
    parameter int  DATA_W     = risc_board_pkg::DATA_W,
    parameter int  LED_W      = risc_board_pkg::LED_W,
    parameter int  DEPTH      = risc_board_pkg::DEPTH,
    parameter int  DEB_CYCLES = risc_board_pkg::DEB_CYCLES,
    parameter int  HB_CYCLES  = risc_board_pkg::HB_CYCLES,
    localparam int SEL_W      = clog2_min1(DATA_W / LED_W),
    localparam int CNT_W      = clog2_min1(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              btn_raw,
    input  logic              freeze,
    input  logic [SEL_W-1:0]  sw_sel,
    output logic [LED_W-1:0]  led,
    output logic [CNT_W-1:0]  hist_cnt
);
    localparam int               PTR_W    = clog2_min1(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
`ifdef LED_HEARTBEAT_EN
    localparam int               SLICE_W  = LED_W - 1;
`else
    localparam int               SLICE_W  = LED_W;
`endif

    generate
        if ((DATA_W % LED_W) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HB_CYCLES < 1) begin : g_bad_params
            $error("risc_led_monitor: illegal parameter combination");
        end
    endgenerate

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_live;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_off;
    logic [CNT_W-1:0]   r_hist_cnt;
    logic               r_freeze_d;
    logic [LED_W-1:0]   r_led;

    logic               w_step;
    logic               w_load;
    logic               w_write;
    logic               w_freeze_rise;
    logic               w_rd_wrap;
    logic [PTR_W-1:0]   w_newest_idx;
    logic [PTR_W-1:0]   w_rd_idx;
    logic [DATA_W-1:0]  w_display;
    logic [SLICE_W-1:0] w_slice;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .step_pulse (w_step)
    );

    assign w_newest_idx  = r_wr_ptr - PTR_W'(1);
    assign w_rd_idx      = w_newest_idx - r_rd_off;
    assign w_load        = data_valid & ~freeze;
    assign w_write       = w_load & ((r_hist_cnt == '0) | (data_in != r_mem[w_newest_idx]));
    assign w_freeze_rise = freeze & ~r_freeze_d;
    assign w_rd_wrap     = (r_hist_cnt == '0) | (CNT_W'(r_rd_off) == r_hist_cnt - CNT_W'(1));

    // History contents survive reset on purpose; hist_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live     <= '0;
            r_wr_ptr   <= '0;
            r_hist_cnt <= '0;
        end else if (w_load) begin
            r_live <= data_in;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (r_hist_cnt != CNT_FULL) begin
                    r_hist_cnt <= r_hist_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Browse offset is held at zero in live mode and on the cycle browse mode is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_off   <= '0;
            r_freeze_d <= 1'b0;
        end else begin
            r_freeze_d <= freeze;
            if (!freeze || w_freeze_rise) begin
                r_rd_off <= '0;
            end else if (w_step) begin
                r_rd_off <= w_rd_wrap ? '0 : r_rd_off + PTR_W'(1);
            end
        end
    end

    always_comb begin
        w_display = r_live;
        if (freeze) begin
            w_display = (r_hist_cnt == '0) ? '0 : r_mem[w_rd_idx];
        end
    end

    // A shift of DATA_W or more yields zero, which blanks out-of-range selections.
    assign w_slice = SLICE_W'(w_display >> (32'(sw_sel) * LED_W));

`ifdef LED_HEARTBEAT_EN
    localparam int              HB_W   = clog2_min1(HB_CYCLES);
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(HB_CYCLES - 1);

    logic [HB_W-1:0] r_hb_cnt;
    logic            r_hb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (r_hb_cnt == HB_MAX) begin
            r_hb_cnt <= '0;
            r_hb     <= ~r_hb;
        end else begin
            r_hb_cnt <= r_hb_cnt + HB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= {r_hb, w_slice};
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_slice;
        end
    end
`endif

    assign led      = r_led;
    assign hist_cnt = r_hist_cnt;

endmodule

// File: tb/tb_risc_led_monitor.sv
// Bench for risc_led_monitor with DEPTH=4, DEB_CYCLES=4; when LED_HEARTBEAT_EN is
// defined led[7] is excluded from slice checks and its period is checked instead.
module tb_risc_led_monitor;

    localparam int DATA_W     = 32;
    localparam int LED_W      = 8;
    localparam int DEPTH      = 4;
    localparam int DEB_CYCLES = 4;
    localparam int HB_CYCLES  = 3;
`ifdef LED_HEARTBEAT_EN
    localparam logic [7:0] LED_MASK = 8'h7F;
`else
    localparam logic [7:0] LED_MASK = 8'hFF;
`endif

    typedef struct {
        logic        dataValid;
        logic [31:0] dataIn;
        logic [1:0]  swSel;
        logic [7:0]  expLed;
        logic [2:0]  expCnt;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dataIn = '0;
    logic        dataValid = 1'b0;
    logic        btnRaw = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  swSel = '0;
    logic [7:0]  led;
    logic [2:0]  histCnt;

    int testCount = 0;
    int failCount = 0;

    vec_t        vecs[$];
    logic [31:0] histQ[$];
    logic [31:0] mLive;
    bit          mFreeze;
    int          mRdOff;
    logic [1:0]  mSel;

    risc_led_monitor #(
        .DATA_W     (DATA_W),
        .LED_W      (LED_W),
        .DEPTH      (DEPTH),
        .DEB_CYCLES (DEB_CYCLES),
        .HB_CYCLES  (HB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (dataIn),
        .data_valid (dataValid),
        .btn_raw    (btnRaw),
        .freeze     (freeze),
        .sw_sel     (swSel),
        .led        (led),
        .hist_cnt   (histCnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkLed(input string name, input logic [7:0] expected);
        checkOutput(name, 32'(led & LED_MASK), 32'(expected & LED_MASK));
    endtask

    task automatic checkCnt(input string name, input int expected);
        checkOutput(name, 32'(histCnt), 32'(expected));
    endtask

    // Press long enough to be accepted, then release long enough to settle low.
    task automatic pressButton();
        btnRaw = 1'b1;
        repeat (10) tick();
        btnRaw = 1'b0;
        repeat (10) tick();
    endtask

    function automatic vec_t mkVec(input logic dv, input logic [31:0] d, input logic [1:0] sel,
                                   input logic [7:0] expLed, input logic [2:0] expCnt, input string name);
        vec_t v;
        v.dataValid = dv;
        v.dataIn    = d;
        v.swSel     = sel;
        v.expLed    = expLed;
        v.expCnt    = expCnt;
        v.name      = name;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        dataValid = v.dataValid;
        dataIn    = v.dataIn;
        swSel     = v.swSel;
        tick();
        dataValid = 1'b0;
        tick();
        checkLed({v.name, "_led"}, v.expLed);
        checkCnt({v.name, "_cnt"}, int'(v.expCnt));
    endtask

    function automatic logic [7:0] modelLed();
        logic [31:0] disp;
        if (mFreeze) begin
            disp = (histQ.size() == 0) ? 32'h0 : histQ[histQ.size() - 1 - mRdOff];
        end else begin
            disp = mLive;
        end
        return 8'(disp >> (8 * int'(mSel)));
    endfunction

    initial begin
        logic [31:0] pool [6];
        int          pulses;
        int          earlyPulses;

        pool[0] = 32'h11223344;
        pool[1] = 32'hA5A5A5A5;
        pool[2] = 32'h000000FF;
        pool[3] = 32'hDEADBEEF;
        pool[4] = 32'h12345678;
        pool[5] = 32'h00000000;

        vecs.push_back(mkVec(1'b1, 32'h12345678, 2'd0, 8'h78, 3'd1, "first_write"));
        vecs.push_back(mkVec(1'b0, 32'h0,        2'd3, 8'h12, 3'd1, "sel_top"));
        vecs.push_back(mkVec(1'b1, 32'hA,        2'd0, 8'h0A, 3'd2, "write_a"));
        vecs.push_back(mkVec(1'b1, 32'hA,        2'd0, 8'h0A, 3'd2, "dup_a"));
        vecs.push_back(mkVec(1'b1, 32'hB,        2'd0, 8'h0B, 3'd3, "write_b"));
        vecs.push_back(mkVec(1'b1, 32'hC,        2'd0, 8'h0C, 3'd4, "write_c"));
        vecs.push_back(mkVec(1'b1, 32'hD,        2'd0, 8'h0D, 3'd4, "write_d_full"));
        vecs.push_back(mkVec(1'b1, 32'hE,        2'd0, 8'h0E, 3'd4, "write_e_full"));
        vecs.push_back(mkVec(1'b0, 32'h0,        2'd1, 8'h00, 3'd4, "sel_byte1"));
        vecs.push_back(mkVec(1'b0, 32'h0,        2'd0, 8'h0E, 3'd4, "sel_back"));

        // Reset state
        repeat (3) tick();
        checkOutput("reset_led", 32'(led), 32'h0);
        checkCnt("reset_cnt", 0);
        reset = 1'b0;
        tick();

        // Two-cycle data latency and one-cycle select latency
        dataIn = 32'h12345678;
        dataValid = 1'b1;
        tick();
        dataValid = 1'b0;
        checkLed("lat_n1", 8'h00);
        tick();
        checkLed("lat_n2", 8'h78);
        swSel = 2'd3;
        tick();
        checkLed("sel_lat", 8'h12);

        // Bouncing button: only the final stable press is accepted
        pulses = 0;
        earlyPulses = 0;
        for (int c = 0; c < 10; c++) begin
            btnRaw = ((c / 2) % 2) == 0;
            tick();
            pulses += int'(dut.u_deb.step_pulse);
        end
        btnRaw = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            pulses += int'(dut.u_deb.step_pulse);
            if (c == 5) earlyPulses = pulses;
        end
        btnRaw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            pulses += int'(dut.u_deb.step_pulse);
        end
        checkOutput("deb_pulse_in_window", 32'(earlyPulses), 32'd1);
        checkOutput("deb_pulse_total", 32'(pulses), 32'd1);
        checkLed("live_ignores_step", 8'h12);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Browse walks newest to oldest and wraps
        freeze = 1'b1;
        tick();
        tick();
        checkLed("browse_0", 8'h0E);
        pressButton();
        checkLed("browse_1", 8'h0D);
        pressButton();
        checkLed("browse_2", 8'h0C);
        pressButton();
        checkLed("browse_3", 8'h0B);
        pressButton();
        checkLed("browse_wrap", 8'h0E);

        // Freeze rising edge beats a coincident data_valid
        freeze = 1'b0;
        tick();
        tick();
        checkLed("live_again", 8'h0E);
        freeze = 1'b1;
        dataValid = 1'b1;
        dataIn = 32'hFF;
        tick();
        dataValid = 1'b0;
        tick();
        tick();
        checkCnt("freeze_wins_cnt", 4);
        checkLed("freeze_wins_led", 8'h0E);
        freeze = 1'b0;
        tick();
        tick();
        checkLed("freeze_wins_live", 8'h0E);

        // Asynchronous reset mid-browse
        freeze = 1'b1;
        tick();
        tick();
        pressButton();
        checkLed("pre_reset_browse", 8'h0D);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_led", 32'(led), 32'h0);
        checkCnt("async_reset_cnt", 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        checkLed("browse_empty", 8'h00);
        checkCnt("browse_empty_cnt", 0);
        freeze = 1'b0;
        tick();
        tick();
        checkLed("live_after_reset", 8'h00);

        // Random operations against the history model
        histQ.delete();
        mLive = '0;
        mFreeze = 1'b0;
        mRdOff = 0;
        mSel = '0;
        swSel = '0;
        tick();
        for (int op = 0; op < 80; op++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind <= 4) begin
                logic [31:0] d;
                d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : pool[$urandom_range(0, 5)];
                dataIn = d;
                dataValid = 1'b1;
                tick();
                dataValid = 1'b0;
                tick();
                tick();
                if (!mFreeze) begin
                    mLive = d;
                    if (histQ.size() == 0 || d != histQ[$]) begin
                        histQ.push_back(d);
                        if (histQ.size() > DEPTH) void'(histQ.pop_front());
                    end
                end
            end else if (kind <= 6) begin
                freeze = ~freeze;
                mFreeze = freeze;
                mRdOff = 0;
                tick();
                tick();
            end else if (kind == 7) begin
                pressButton();
                if (mFreeze) mRdOff = (histQ.size() == 0) ? 0 : (mRdOff + 1) % histQ.size();
            end else begin
                swSel = 2'($urandom_range(0, 3));
                mSel = swSel;
                tick();
                tick();
            end
            checkLed($sformatf("rand_led_%0d", op), modelLed());
            checkCnt($sformatf("rand_cnt_%0d", op), histQ.size());
        end

`ifdef LED_HEARTBEAT_EN
        begin
            logic prevHb;
            int   lastToggle;
            int   toggles;
            prevHb = led[7];
            lastToggle = -1;
            toggles = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (led[7] !== prevHb) begin
                    if (lastToggle >= 0) checkOutput("hb_period", 32'(c - lastToggle), 32'(HB_CYCLES));
                    lastToggle = c;
                    prevHb = led[7];
                    toggles++;
                end
            end
            checkOutput("hb_toggle_count", 32'(toggles >= 9), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
